// File: rtl/mul_seq_ctrl.sv
// Sequential WIDTH x WIDTH unsigned multiplier controller time-sharing one external 2x2 multiplier.
// Optional MUL_SEQ_SKIPZERO_EN: zero operands bypass RUN and go straight to DONE with product 0.
module mul_seq_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [WIDTH-1:0]     a_i,
  input  logic [WIDTH-1:0]     b_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [2*WIDTH-1:0]   product_o,
  output logic                 busy_o,
  output logic [1:0]           mul_a_o,
  output logic [1:0]           mul_b_o,
  input  logic [3:0]           mul_m_i
);

  localparam int unsigned N  = WIDTH / 2;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned PW = 2 * WIDTH;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state_q;
  logic [CW-1:0]     i_q, j_q;
  logic [WIDTH-1:0]  a_q, b_q;
  logic [PW-1:0]     acc_q, acc_sum;
  logic [PW-1:0]     product_q;
  logic              out_valid_q, busy_q;
  logic [CW+1:0]     shamt;
  logic              last_pair;

  // Digit weight of pair (i,j) is 4^(i+j), i.e. a left shift by 2*(i+j).
  always_comb begin
    shamt     = ({2'b00, i_q} + {2'b00, j_q}) << 1;
    acc_sum   = acc_q + ({{(PW-4){1'b0}}, mul_m_i} << shamt);
    last_pair = (i_q == CW'(N - 1)) && (j_q == CW'(N - 1));
    mul_a_o   = 2'b00;
    mul_b_o   = 2'b00;
    if (state_q == StRun) begin
      mul_a_o = a_q[{i_q, 1'b0} +: 2];
      mul_b_o = b_q[{j_q, 1'b0} +: 2];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      i_q         <= '0;
      j_q         <= '0;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      product_q   <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid_i) begin
            a_q   <= a_i;
            b_q   <= b_i;
            acc_q <= '0;
            i_q   <= '0;
            j_q   <= '0;
`ifdef MUL_SEQ_SKIPZERO_EN
            if ((a_i == '0) || (b_i == '0)) begin
              state_q     <= StDone;
              out_valid_q <= 1'b1;
              product_q   <= '0;
            end else begin
              state_q <= StRun;
              busy_q  <= 1'b1;
            end
`else
            state_q <= StRun;
            busy_q  <= 1'b1;
`endif
          end
        end
        StRun: begin
          acc_q <= acc_sum;
          if (i_q == CW'(N - 1)) begin
            i_q <= '0;
            j_q <= j_q + CW'(1);
          end else begin
            i_q <= i_q + CW'(1);
          end
          if (last_pair) begin
            state_q     <= StDone;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b1;
            product_q   <= acc_sum;
            j_q         <= '0;
          end
        end
        StDone: begin
          if (out_ready_i) begin
            state_q     <= StIdle;
            out_valid_q <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_ready_o  = (state_q == StIdle);
  assign out_valid_o = out_valid_q;
  assign product_o   = product_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Randomized and directed bench for mul_seq_ctrl against a cycle-level behavioural model.
module tb_mul_seq_ctrl;

  localparam int unsigned W = 8;
  localparam int unsigned N = W / 2;
`ifdef MUL_SEQ_SKIPZERO_EN
  localparam bit Skip = 1'b1;
`else
  localparam bit Skip = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic         in_valid, in_ready, out_valid, out_ready, busy;
  logic [W-1:0] a, b;
  logic [2*W-1:0] product;
  logic [1:0]   mul_a, mul_b;
  logic [3:0]   mul_m;
  assign mul_m = 4'(mul_a) * 4'(mul_b);

  mul_seq_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .a_i(a), .b_i(b), .out_valid_o(out_valid), .out_ready_i(out_ready),
    .product_o(product), .busy_o(busy), .mul_a_o(mul_a), .mul_b_o(mul_b), .mul_m_i(mul_m)
  );

  // Narrow instance for the WIDTH=4 case.
  logic       s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_busy;
  logic [3:0] s_a, s_b;
  logic [7:0] s_product;
  logic [1:0] s_mul_a, s_mul_b;
  logic [3:0] s_mul_m;
  assign s_mul_m = 4'(s_mul_a) * 4'(s_mul_b);

  mul_seq_ctrl #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid_i(s_in_valid), .in_ready_o(s_in_ready),
    .a_i(s_a), .b_i(s_b), .out_valid_o(s_out_valid), .out_ready_i(s_out_ready),
    .product_o(s_product), .busy_o(s_busy), .mul_a_o(s_mul_a), .mul_b_o(s_mul_b),
    .mul_m_i(s_mul_m)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: remaining RUN cycles, pending product, and whether a result is on offer.
  int            m_left;
  bit            m_valid;
  logic [2*W-1:0] m_prod, m_pend;
  logic [W-1:0]  m_a, m_b;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left = 0; m_valid = 0; m_prod = '0; m_pend = '0; m_a = '0; m_b = '0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        m_valid = 1'b1;
        m_prod  = m_pend;
      end
    end else if (m_valid) begin
      if (out_ready) m_valid = 1'b0;
    end else if (in_valid) begin
      m_a    = a;
      m_b    = b;
      m_pend = (2*W)'(a) * (2*W)'(b);
      if (Skip && (a == 0 || b == 0)) begin
        m_valid = 1'b1;
        m_prod  = '0;
      end else begin
        m_left = N * N;
      end
    end
  end

  always @(posedge clk) begin
    int k;
    logic [1:0] ea, eb;
    #1;
    if (rst_n) begin
      ea = 2'b00;
      eb = 2'b00;
      if (m_left > 0) begin
        k  = N * N - m_left;
        ea = 2'((m_a >> (2 * (k % N))) & 3);
        eb = 2'((m_b >> (2 * (k / N))) & 3);
      end
      check("in_ready", in_ready, (m_left == 0) && !m_valid);
      check("busy", busy, m_left > 0);
      check("out_valid", out_valid, m_valid);
      check("mul_a", mul_a, ea);
      check("mul_b", mul_b, eb);
      if (m_valid) check("product", product, m_prod);
    end
  end

  // Offer one operand pair, wait for the result, hold it 'hold' cycles, then take it.
  task automatic txn(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input int hold,
                     input bit keep_valid, output int lat, output int bcnt,
                     output logic [2*W-1:0] prod);
    @(negedge clk);
    check("pre_in_ready", in_ready, 1);
    a = ta; b = tb_v; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    if (keep_valid) begin a = 7; b = 7; end
    else in_valid = 1'b0;
    lat  = 0;
    bcnt = 0;
    while (!out_valid && lat < 100) begin
      bcnt += int'(busy);
      @(posedge clk); #1;
      lat++;
    end
    if (lat >= 100) check("result_timeout", 0, 1);
    prod = product;
    repeat (hold) @(posedge clk);
    #1;
    if (hold > 0) begin
      check("bp_product", product, prod);
      check("bp_out_valid", out_valid, 1);
      check("bp_in_ready", in_ready, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("post_out_valid", out_valid, 0);
    check("post_in_ready", in_ready, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, bc;
    logic [2*W-1:0] p;
    rst_n = 1'b0; in_valid = 0; out_ready = 0; a = '0; b = '0;
    s_in_valid = 0; s_out_ready = 0; s_a = '0; s_b = '0;
    #12;
    check("rst_product", product, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_mul_ab", {mul_a, mul_b}, 0);
    @(negedge clk); rst_n = 1'b1; #1;
    check("rel_in_ready", in_ready, 1);

    txn(3, 5, 0, 0, lat, bc, p);
    check("t1_latency", lat, N * N);
    check("t1_busy_cycles", bc, N * N);
    check("t1_product", p, 15);
    txn(255, 255, 0, 0, lat, bc, p);
    check("t2_ff", p, 65025);
    txn(170, 85, 0, 0, lat, bc, p);
    check("t2_aa55", p, 14450);
    txn(200, 9, 10, 0, lat, bc, p);
    check("t3_product", p, 1800);
    txn(11, 13, 0, 1, lat, bc, p);
    check("t4_ignore_in_valid", p, 143);
    txn(0, 200, 0, 0, lat, bc, p);
    check("t6_latency", lat, Skip ? 0 : N * N);
    check("t6_busy_cycles", bc, Skip ? 0 : N * N);
    check("t6_product", p, 0);

    // Abort mid-RUN with an asynchronous reset.
    @(negedge clk); a = 200; b = 100; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0; #1;
    check("t5_busy", busy, 0);
    check("t5_out_valid", out_valid, 0);
    check("t5_product", product, 0);
    check("t5_mul_ab", {mul_a, mul_b}, 0);
    @(negedge clk); rst_n = 1'b1;
    txn(2, 3, 0, 0, lat, bc, p);
    check("t5_after", p, 6);

    // WIDTH=4 instance.
    @(negedge clk); s_a = 15; s_b = 13; s_in_valid = 1'b1; s_out_ready = 1'b1;
    @(posedge clk); #1; s_in_valid = 1'b0;
    lat = 0;
    while (!s_out_valid && lat < 50) begin @(posedge clk); #1; lat++; end
    check("t7_latency", lat, 4);
    check("t7_product", s_product, 195);
    @(posedge clk); #1;
    check("t7_released", s_out_valid, 0);

    // Random traffic; the compare process does the checking.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      in_valid  = ($urandom_range(0, 3) == 0);
      a         = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
      b         = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
      out_ready = $urandom_range(0, 1) == 1;
    end
    @(negedge clk); in_valid = 0; out_ready = 1;
    repeat (3) @(posedge clk);
    #2;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
